// File: rtl/ssp_tx_shifter.sv
// SSP transmit serialiser: pulls bytes from a first-word-fallthrough FIFO and shifts them out with pclk/2 serial clock and frame sync.
// Optional build macro SSP_TX_LSB_FIRST_EN selects LSB-first shifting (default MSB first).
module ssp_tx_shifter (
   input  logic       pclk,
   input  logic       clr_b,
   input  logic [7:0] tx_data,
   input  logic       tx_empty,
   output logic       tx_pop,
   output logic       ssp_clk_out,
   output logic       ssp_fss_out,
   output logic       ssp_txd,
   output logic       ssp_oe_b,
   output logic       tx_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   state_e     state_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] shreg_q;
   logic       next_pending_q;
   logic       clk_q;
   logic       clk_d;
   logic       fss_q;
   logic       txd_q;
   logic       oe_b_q;
   logic       boundary_s;
   logic       reload_s;

`ifdef SSP_TX_LSB_FIRST_EN
   function automatic logic lead_bit(input logic [7:0] w);
      return w[0];
   endfunction

   function automatic logic [7:0] advance(input logic [7:0] w);
      return {1'b0, w[7:1]};
   endfunction
`else
   function automatic logic lead_bit(input logic [7:0] w);
      return w[7];
   endfunction

   function automatic logic [7:0] advance(input logic [7:0] w);
      return {w[6:0], 1'b0};
   endfunction
`endif

   // Boundary detection and the FIFO pop request for a word load at the coming boundary.
   always_comb begin
      clk_d      = ~clk_q;
      boundary_s = ~clk_q;
      reload_s   = 1'b0;
      case (state_q)
         ST_FRAME: reload_s = 1'b1;
         ST_SHIFT: reload_s = (bit_cnt_q == 3'd7) && next_pending_q;
         default:  reload_s = 1'b0;
      endcase
      if (boundary_s) begin
         tx_pop = reload_s;
      end else begin
         tx_pop = 1'b0;
      end
   end

   // Serial clock divider and the framing state machine; all pad outputs are registered here.
   always_ff @(posedge pclk or negedge clr_b) begin
      if (!clr_b) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= 3'd0;
         shreg_q        <= 8'd0;
         next_pending_q <= 1'b0;
         clk_q          <= 1'b0;
         fss_q          <= 1'b0;
         txd_q          <= 1'b0;
         oe_b_q         <= 1'b1;
      end else begin
         clk_q <= clk_d;
         if (boundary_s) begin
            if (reload_s) begin
               // Word load: shared by the FRAME period and a committed back-to-back frame.
               shreg_q        <= advance(tx_data);
               txd_q          <= lead_bit(tx_data);
               oe_b_q         <= 1'b0;
               fss_q          <= 1'b0;
               bit_cnt_q      <= 3'd0;
               next_pending_q <= 1'b0;
               state_q        <= ST_SHIFT;
            end else begin
               case (state_q)
                  ST_IDLE: begin
                     txd_q  <= 1'b0;
                     oe_b_q <= 1'b1;
                     if (!tx_empty) begin
                        fss_q   <= 1'b1;
                        state_q <= ST_FRAME;
                     end else begin
                        fss_q   <= 1'b0;
                        state_q <= ST_IDLE;
                     end
                  end
                  ST_SHIFT: begin
                     if (bit_cnt_q != 3'd7) begin
                        txd_q     <= lead_bit(shreg_q);
                        shreg_q   <= advance(shreg_q);
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        // The LSB-start boundary is the only point a following word is committed.
                        if ((bit_cnt_q == 3'd6) && !tx_empty) begin
                           fss_q          <= 1'b1;
                           next_pending_q <= 1'b1;
                        end else begin
                           fss_q          <= 1'b0;
                        end
                     end else begin
                        txd_q          <= 1'b0;
                        oe_b_q         <= 1'b1;
                        fss_q          <= 1'b0;
                        bit_cnt_q      <= 3'd0;
                        next_pending_q <= 1'b0;
                        state_q        <= ST_IDLE;
                     end
                  end
                  default: begin
                     txd_q          <= 1'b0;
                     oe_b_q         <= 1'b1;
                     fss_q          <= 1'b0;
                     bit_cnt_q      <= 3'd0;
                     next_pending_q <= 1'b0;
                     state_q        <= ST_IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign ssp_clk_out = clk_q;
   assign ssp_fss_out = fss_q;
   assign ssp_txd     = txd_q;
   assign ssp_oe_b    = oe_b_q;
   assign tx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ssp_tx_shifter.sv
// Scoreboard bench for ssp_tx_shifter: a FIFO model feeds words, expected serial bits are queued per word
// and a monitor compares every serial period; honours SSP_TX_LSB_FIRST_EN for bit order.
module tb_ssp_tx_shifter;

   logic       pclk = 1'b0;
   logic       clr_b = 1'b0;
   logic [7:0] tx_data;
   logic       tx_empty;
   logic       tx_pop;
   logic       ssp_clk_out;
   logic       ssp_fss_out;
   logic       ssp_txd;
   logic       ssp_oe_b;
   logic       tx_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   int n_words  = 0;

   logic [7:0] fifo_q[$];
   logic       exp_bits[$];

   int   bit_idx    = 0;
   int   words_done = 0;
   int   run_len    = 0;
   int   gap_len    = 0;
   int   last_run   = 0;
   int   last_gap   = 0;
   logic prev_fss   = 1'b0;
   logic prev_clk   = 1'b0;
   logic prev_valid = 1'b0;
   logic pop_seen   = 1'b0;
   logic found;
   logic ok;
   int   w0;

   ssp_tx_shifter dut (
      .pclk        (pclk),
      .clr_b       (clr_b),
      .tx_data     (tx_data),
      .tx_empty    (tx_empty),
      .tx_pop      (tx_pop),
      .ssp_clk_out (ssp_clk_out),
      .ssp_fss_out (ssp_fss_out),
      .ssp_txd     (ssp_txd),
      .ssp_oe_b    (ssp_oe_b),
      .tx_busy     (tx_busy)
   );

   initial forever #5 pclk = ~pclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue a word into the FIFO model and its serial bits into the scoreboard.
   task automatic push_word(input logic [7:0] w);
      @(negedge pclk);
      #1;
      fifo_q.push_back(w);
      n_words++;
      for (int i = 0; i < 8; i++) begin
`ifdef SSP_TX_LSB_FIRST_EN
         exp_bits.push_back(w[i]);
`else
         exp_bits.push_back(w[7-i]);
`endif
      end
   endtask

   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 6000 && !done; i++) begin
         @(negedge pclk);
         #1;
         if (fifo_q.size() == 0 && !tx_busy) done = 1'b1;
      end
      check(name, done, 1);
      repeat (2) @(negedge pclk);
      #1;
   endtask

   // FIFO model: first-word-fallthrough, advances after a pclk edge that ended a tx_pop cycle.
   initial begin
      tx_empty = 1'b1;
      tx_data  = 8'h00;
      forever begin
         @(negedge pclk);
         pop_seen = tx_pop && clr_b;
         if (tx_pop) check("pop_nonempty", tx_empty, 0);
         if (!clr_b) check("pop_in_reset", tx_pop, 0);
         #2;
         tx_empty = (fifo_q.size() == 0);
         tx_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
         @(posedge pclk);
         #1;
         if (pop_seen && clr_b && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            n_pops++;
         end
         tx_empty = (fifo_q.size() == 0);
         tx_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
      end
   end

   // Monitor: one serial sample per period (ssp_clk_out high), plus per-pclk clock/busy/enable checks.
   initial forever begin
      int  pos;
      logic b;
      @(negedge pclk);
      if (!clr_b) begin
         prev_valid = 1'b0;
         bit_idx    = 0;
         run_len    = 0;
         gap_len    = 0;
         prev_fss   = 1'b0;
      end else begin
         if (prev_valid) check("clk_toggle", ssp_clk_out, !prev_clk);
         prev_clk   = ssp_clk_out;
         prev_valid = 1'b1;
         check("busy", tx_busy, (!ssp_oe_b) || ssp_fss_out);
         if (!ssp_oe_b) begin
            if (gap_len > 0) last_gap = gap_len;
            gap_len = 0;
            run_len++;
         end else begin
            gap_len++;
            if (run_len > 0) begin
               last_run = run_len;
               check("oe_run_len_mod16", run_len % 16, 0);
            end
            run_len = 0;
         end
         if (ssp_clk_out) begin
            pos = bit_idx;
            if (prev_fss) check("fss_then_msb", (!ssp_oe_b) && (pos == 0), 1);
            if (!ssp_oe_b) begin
               check("bits_available", exp_bits.size() > 0, 1);
               if (exp_bits.size() > 0) begin
                  b = exp_bits.pop_front();
                  check("txd", ssp_txd, b);
               end
               if (pos == 0) check("fss_before_msb", prev_fss, 1);
               bit_idx = (bit_idx + 1) % 8;
               if (bit_idx == 0) words_done++;
            end else begin
               check("txd_idle", ssp_txd, 0);
               check("idle_on_word_edge", bit_idx, 0);
            end
            prev_fss = ssp_fss_out;
         end
      end
   end

   initial begin
      // Reset held with FIFO occupied.
      clr_b = 1'b0;
      push_word(8'h35);
      repeat (3) begin
         @(negedge pclk);
         #1;
         check("rst_oe_b", ssp_oe_b, 1);
         check("rst_txd", ssp_txd, 0);
         check("rst_fss", ssp_fss_out, 0);
         check("rst_pop", tx_pop, 0);
         check("rst_clk", ssp_clk_out, 0);
         check("rst_busy", tx_busy, 0);
      end
      @(negedge pclk);
      #1;
      clr_b = 1'b1;
      @(negedge pclk);
      #1;
      check("no_pop_after_release", tx_pop, 0);
      wait_idle("idle_single");
      check("single_oe_run", last_run, 16);
      check("single_pops", n_pops, 1);

      // Back-to-back pair with latency checks on the first word.
      push_word(8'h35);
      found = 1'b0;
      for (int i = 0; i < 2 && !found; i++) begin
         @(posedge pclk);
         #1;
         if (ssp_fss_out) found = 1'b1;
      end
      check("fss_latency", found, 1);
      repeat (2) @(posedge pclk);
      #1;
      check("msb_2pclk_after_fss", ssp_oe_b, 0);
      push_word(8'hAE);
      wait_idle("idle_b2b");
      check("b2b_oe_run", last_run, 32);
      check("b2b_pops", n_pops, 3);

      // Late arrival after LSB start of 0x26.
      push_word(8'h26);
      w0 = words_done;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge pclk);
         #1;
         if (words_done != w0) ok = 1'b1;
      end
      check("late_lsb_seen", ok, 1);
      push_word(8'hAE);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge pclk);
         #1;
         if (ssp_oe_b) ok = 1'b1;
      end
      check("late_oe_rises", ok, 1);
      check("late_first_run", last_run, 16);
      wait_idle("idle_late");
      check("late_second_run", last_run, 16);
      check("late_gap_ge_period", last_gap >= 2, 1);

      // Asynchronous reset in the middle of 0x9D.
      push_word(8'h9D);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge pclk);
         #1;
         if (bit_idx == 4 && !ssp_oe_b) ok = 1'b1;
      end
      check("abort_reach_bit4", ok, 1);
      @(posedge pclk);
      #3;
      clr_b = 1'b0;
      #1;
      check("abort_oe_b", ssp_oe_b, 1);
      check("abort_txd", ssp_txd, 0);
      check("abort_fss", ssp_fss_out, 0);
      check("abort_clk", ssp_clk_out, 0);
      check("abort_busy", tx_busy, 0);
      check("abort_pop", tx_pop, 0);
      exp_bits.delete();
      push_word(8'h5A);
      repeat (3) @(negedge pclk);
      #1;
      clr_b = 1'b1;
      @(negedge pclk);
      #1;
      check("abort_no_pop_after_release", tx_pop, 0);
      wait_idle("idle_abort");
      check("abort_pops", n_pops, n_words);

      // Randomised traffic with random gaps.
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 40)) @(negedge pclk);
         push_word(8'($urandom));
      end
      wait_idle("idle_random");

      // Bit-order pattern (order follows the build macro in push_word).
      push_word(8'h8F);
      wait_idle("idle_8f");

      check("pops_eq_words", n_pops, n_words);
      check("scoreboard_drained", exp_bits.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
